// File: rtl/jala_mem_pkg.sv
// jala_mem_pkg: memory map defaults for the JALA stacks and a region sanity check
// Holds the MS/RS base and depth defaults, the instruction base, and a helper
// that confirms the two stack regions are disjoint and sit below the program.
package jala_mem_pkg;
    localparam logic [15:0] MS_BASE    = 16'h2000;
    localparam int          MS_DEPTH   = 1024;
    localparam logic [15:0] RS_BASE    = 16'h2400;
    localparam int          RS_DEPTH   = 1024;
    localparam logic [15:0] INSTR_BASE = 16'h2800;

    // Each region spans [base-depth, base-1]; regions must not overlap and
    // must end below the instruction area.
    function automatic bit regions_ok(input int ms_base, input int ms_depth,
                                      input int rs_base, input int rs_depth,
                                      input int instr_base);
        bit disjoint;
        disjoint = (ms_base <= rs_base - rs_depth) || (rs_base <= ms_base - ms_depth);
        return disjoint && (ms_base <= instr_base) && (rs_base <= instr_base)
            && (ms_base >= ms_depth + 1) && (rs_base >= rs_depth + 1);
    endfunction
endpackage

// File: rtl/stack_ptr_core.sv
// stack_ptr_core: one downward-growing stack pointer with bounds checks and high-water mark
// Ports: clk, rst (sync, active-high); write/pop/reg_reset strobes in;
// tos/nos/push addresses, depth, hwm, empty/full and sticky ovf/unf out.
module stack_ptr_core #(
    parameter logic [15:0] BASE  = 16'h2000,
    parameter int          DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write,
    input  logic        pop,
    input  logic        reg_reset,
    output logic [15:0] tos_addr,
    output logic [15:0] nos_addr,
    output logic [15:0] push_addr,
    output logic [15:0] depth,
    output logic [15:0] hwm,
    output logic        empty,
    output logic        full,
    output logic        ovf,
    output logic        unf
);
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
            hwm   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (reg_reset) begin
            depth <= '0;
        end else if (write && pop) begin
            if (empty) unf <= 1'b1;
            else depth <= depth - 16'd1;
        end else if (write) begin
            if (full) ovf <= 1'b1;
            else begin
                depth <= depth + 16'd1;
                // hwm never trails depth, so the new depth is the only candidate
                if (depth + 16'd1 > hwm) hwm <= depth + 16'd1;
            end
        end
    end

    always_comb begin
        tos_addr  = BASE - depth;
        nos_addr  = tos_addr + 16'd1;
        push_addr = tos_addr - 16'd1;
        empty     = depth == 16'd0;
        full      = depth == DEPTH_W;
    end
endmodule

// File: rtl/stack_pointer_unit.sv
// stack_pointer_unit: main-stack and return-stack pointers for the JALA CPU
// Ports: clk, rst; MSPWrite/MSPop/MSPRegReset and RSPWrite/RSPop/RSPRegReset
// strobes from control; MS/RS addresses, depths, high-water marks, empty/full
// and sticky overflow/underflow flags out. All outputs follow the registered depth.
module stack_pointer_unit
    import jala_mem_pkg::*;
#(
    parameter logic [15:0] MS_BASE  = jala_mem_pkg::MS_BASE,
    parameter int          MS_DEPTH = jala_mem_pkg::MS_DEPTH,
    parameter logic [15:0] RS_BASE  = jala_mem_pkg::RS_BASE,
    parameter int          RS_DEPTH = jala_mem_pkg::RS_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MSPWrite,
    input  logic        MSPop,
    input  logic        MSPRegReset,
    input  logic        RSPWrite,
    input  logic        RSPop,
    input  logic        RSPRegReset,
    output logic [15:0] ms_tos_addr,
    output logic [15:0] ms_nos_addr,
    output logic [15:0] ms_push_addr,
    output logic [15:0] rs_tos_addr,
    output logic [15:0] rs_push_addr,
    output logic [15:0] ms_depth,
    output logic [15:0] rs_depth,
    output logic [15:0] ms_hwm,
    output logic [15:0] rs_hwm,
    output logic        ms_empty,
    output logic        ms_full,
    output logic        rs_empty,
    output logic        rs_full,
    output logic        ms_ovf,
    output logic        ms_unf,
    output logic        rs_ovf,
    output logic        rs_unf
);
    if (!regions_ok(int'(MS_BASE), MS_DEPTH, int'(RS_BASE), RS_DEPTH, int'(INSTR_BASE))) begin : g_bad_map
        $error("stack regions overlap or reach the instruction area");
    end

    // The return stack has no consumer for its second-element address.
    logic [15:0] rs_nos_unused;

    stack_ptr_core #(.BASE(MS_BASE), .DEPTH(MS_DEPTH)) u_ms (
        .clk(clk), .rst(rst), .write(MSPWrite), .pop(MSPop), .reg_reset(MSPRegReset),
        .tos_addr(ms_tos_addr), .nos_addr(ms_nos_addr), .push_addr(ms_push_addr),
        .depth(ms_depth), .hwm(ms_hwm), .empty(ms_empty), .full(ms_full),
        .ovf(ms_ovf), .unf(ms_unf)
    );

    stack_ptr_core #(.BASE(RS_BASE), .DEPTH(RS_DEPTH)) u_rs (
        .clk(clk), .rst(rst), .write(RSPWrite), .pop(RSPop), .reg_reset(RSPRegReset),
        .tos_addr(rs_tos_addr), .nos_addr(rs_nos_unused), .push_addr(rs_push_addr),
        .depth(rs_depth), .hwm(rs_hwm), .empty(rs_empty), .full(rs_full),
        .ovf(rs_ovf), .unf(rs_unf)
    );

    logic unused_ok;
    assign unused_ok = ^rs_nos_unused;
endmodule

// File: tb/tb_stack_pointer_unit.sv
// tb_stack_pointer_unit: directed self-checking bench for stack_pointer_unit
module tb_stack_pointer_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic MSPWrite = 1'b0, MSPop = 1'b0, MSPRegReset = 1'b0;
    logic RSPWrite = 1'b0, RSPop = 1'b0, RSPRegReset = 1'b0;
    logic [15:0] ms_tos_addr, ms_nos_addr, ms_push_addr, rs_tos_addr, rs_push_addr;
    logic [15:0] ms_depth, rs_depth, ms_hwm, rs_hwm;
    logic ms_empty, ms_full, rs_empty, rs_full, ms_ovf, ms_unf, rs_ovf, rs_unf;
    int checks = 0;
    int failures = 0;

    stack_pointer_unit dut (
        .clk(clk), .rst(rst),
        .MSPWrite(MSPWrite), .MSPop(MSPop), .MSPRegReset(MSPRegReset),
        .RSPWrite(RSPWrite), .RSPop(RSPop), .RSPRegReset(RSPRegReset),
        .ms_tos_addr(ms_tos_addr), .ms_nos_addr(ms_nos_addr), .ms_push_addr(ms_push_addr),
        .rs_tos_addr(rs_tos_addr), .rs_push_addr(rs_push_addr),
        .ms_depth(ms_depth), .rs_depth(rs_depth), .ms_hwm(ms_hwm), .rs_hwm(rs_hwm),
        .ms_empty(ms_empty), .ms_full(ms_full), .rs_empty(rs_empty), .rs_full(rs_full),
        .ms_ovf(ms_ovf), .ms_unf(ms_unf), .rs_ovf(rs_ovf), .rs_unf(rs_unf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ms_tos", ms_tos_addr, 16'h2000);
        chk("rst_ms_nos", ms_nos_addr, 16'h2001);
        chk("rst_ms_push", ms_push_addr, 16'h1FFF);
        chk("rst_rs_tos", rs_tos_addr, 16'h2400);
        chk("rst_rs_push", rs_push_addr, 16'h23FF);
        chk("rst_empty_full", {12'd0, ms_empty, rs_empty, ms_full, rs_full}, 16'b1100);
        chk("rst_flags", {12'd0, ms_ovf, ms_unf, rs_ovf, rs_unf}, 16'd0);
        chk("rst_hwm", ms_hwm | rs_hwm, 16'd0);

        MSPWrite = 1'b1; MSPop = 1'b0;
        step(); chk("ms_push1", ms_depth, 16'd1);
        step(); chk("ms_push2", ms_depth, 16'd2);
        step(); chk("ms_push3", ms_depth, 16'd3);
        MSPop = 1'b1;
        step(); chk("ms_pop_depth", ms_depth, 16'd2);
        MSPWrite = 1'b0;
        chk("ms_tos2", ms_tos_addr, 16'h1FFE);
        chk("ms_nos2", ms_nos_addr, 16'h1FFF);
        chk("ms_push_addr2", ms_push_addr, 16'h1FFD);
        chk("ms_hwm3", ms_hwm, 16'd3);
        step(); chk("ms_hold_pop_dc", ms_depth, 16'd2);

        MSPWrite = 1'b1;
        step(); step();
        chk("ms_drained", ms_depth, 16'd0);
        chk("ms_unf_before", {15'd0, ms_unf}, 16'd0);
        step();
        chk("ms_unf_depth", ms_depth, 16'd0);
        chk("ms_unf_set", {15'd0, ms_unf}, 16'd1);
        MSPop = 1'b0;
        step(); step();
        chk("ms_unf_push_depth", ms_depth, 16'd2);
        MSPWrite = 1'b0; MSPRegReset = 1'b1;
        step();
        MSPRegReset = 1'b0;
        chk("ms_regreset_depth", ms_depth, 16'd0);
        chk("ms_unf_sticky", {15'd0, ms_unf}, 16'd1);
        chk("ms_hwm_kept", ms_hwm, 16'd3);

        RSPWrite = 1'b1; RSPop = 1'b0;
        for (int i = 0; i < 1023; i++) step();
        chk("rs_1023", rs_depth, 16'd1023);
        chk("rs_not_full", {15'd0, rs_full}, 16'd0);
        step();
        chk("rs_1024", rs_depth, 16'd1024);
        chk("rs_full", {15'd0, rs_full}, 16'd1);
        chk("rs_ovf_before", {15'd0, rs_ovf}, 16'd0);
        chk("rs_tos_full", rs_tos_addr, 16'h2000);
        step();
        RSPWrite = 1'b0;
        chk("rs_ovf_depth", rs_depth, 16'd1024);
        chk("rs_ovf_set", {15'd0, rs_ovf}, 16'd1);
        chk("rs_hwm", rs_hwm, 16'd1024);
        RSPRegReset = 1'b1;
        step();
        RSPRegReset = 1'b0;
        chk("rs_regreset", rs_depth, 16'd0);
        chk("rs_ovf_sticky", {15'd0, rs_ovf}, 16'd1);
        chk("rs_hwm_kept", rs_hwm, 16'd1024);

        MSPWrite = 1'b1; MSPop = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("ms_depth5", ms_depth, 16'd5);
        chk("ms_hwm5", ms_hwm, 16'd5);
        MSPRegReset = 1'b1;
        step();
        MSPRegReset = 1'b0; MSPWrite = 1'b0;
        chk("ms_rr_beats_write", ms_depth, 16'd0);
        chk("ms_hwm5_kept", ms_hwm, 16'd5);

        MSPWrite = 1'b1; RSPWrite = 1'b1; MSPop = 1'b0; RSPop = 1'b0;
        step(); step();
        chk("dual_ms2", ms_depth, 16'd2);
        chk("dual_rs2", rs_depth, 16'd2);
        MSPop = 1'b1;
        step();
        RSPWrite = 1'b0;
        chk("dual_rs3", rs_depth, 16'd3);
        chk("dual_ms1", ms_depth, 16'd1);
        MSPop = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; MSPWrite = 1'b0;
        chk("rst2_depths", ms_depth | rs_depth, 16'd0);
        chk("rst2_hwm", ms_hwm | rs_hwm, 16'd0);
        chk("rst2_flags", {12'd0, ms_ovf, ms_unf, rs_ovf, rs_unf}, 16'd0);
        chk("rst2_ms_tos", ms_tos_addr, 16'h2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
